baccarat_ctrl: RTL and testbench

//  Sequencing controller for the baccarat card datapath (dealer + 7-seg/LEDR top).
//  - Decides which card register loads on each slow_clock edge.
//  - Applies the natural / player-draw / banker third-card rules.
//  - Latches the win lights at the end of the hand.
//  - Sits between the datapath (supplies scores and pcard3) and the top-level LEDR.

---
 rtl/baccarat_pkg.sv | 33 +++
 rtl/baccarat_ctrl_if.sv | 35 +++
 rtl/banker_draw_rule.sv | 30 +++
 rtl/baccarat_ctrl.sv | 105 ++++++++++
 tb/tb_baccarat_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/baccarat_pkg.sv
// rtl/baccarat_pkg.sv - shared types and constants for the baccarat sequencing controller
// Purpose: state encoding, card rank type, rank/score constants, card value helper.
// Ports: none (package).
package baccarat_pkg;

  typedef enum logic [3:0] {
    DEAL_P1   = 4'd0,
    DEAL_D1   = 4'd1,
    DEAL_P2   = 4'd2,
    DEAL_D2   = 4'd3,
    EVAL      = 4'd4,
    DEAL_P3   = 4'd5,
    BANK_EVAL = 4'd6,
    DEAL_D3   = 4'd7,
    SCORE     = 4'd8,
    DONE      = 4'd9
  } state_t;

  typedef logic [3:0] card_rank_t;

  localparam card_rank_t NO_CARD      = 4'd0;
  localparam card_rank_t FACE_MIN     = 4'd10;
  localparam logic [3:0] BANKER_STAND = 4'd7;

  // Tens and face cards count zero; a missing card (NO_CARD) also counts zero.
  function automatic logic [3:0] card_value(input card_rank_t rank);
    if (rank >= FACE_MIN || rank == NO_CARD) begin
      return 4'd0;
    end
    return rank;
  endfunction

endpackage

// File: rtl/baccarat_ctrl_if.sv
// rtl/baccarat_ctrl_if.sv - controller <-> datapath/top signal bundle
// Purpose: groups scores, third player card, card load enables, lights and done.
// Ports: master = controller side (reads scores, drives loads/lights/done);
//        slave  = datapath side (drives scores, reads loads/lights/done).
interface baccarat_ctrl_if;
  import baccarat_pkg::*;

  logic [3:0] pscore;
  logic [3:0] dscore;
  card_rank_t pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       done;

  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, done
  );

  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, done
  );

endinterface

// File: rtl/banker_draw_rule.sv
// rtl/banker_draw_rule.sv - banker third-card rule (combinational)
// Purpose: decides whether the banker draws given its two-card score and the
//          player's third card rank.
// Ports: dscore_i (4b banker score), pcard3_i (4b player third rank), draw_o (1b).
module banker_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore_i,
  input  card_rank_t pcard3_i,
  output logic       draw_o
);

  logic [3:0] v;
  assign v = card_value(pcard3_i);

  always_comb begin
    draw_o = 1'b0;
    if (dscore_i < BANKER_STAND) begin
      case (dscore_i)
        4'd0, 4'd1, 4'd2: draw_o = 1'b1;
        4'd3:             draw_o = (v != 4'd8);
        4'd4:             draw_o = (v >= 4'd2) && (v <= 4'd7);
        4'd5:             draw_o = (v >= 4'd4) && (v <= 4'd7);
        4'd6:             draw_o = (v >= 4'd6) && (v <= 4'd7);
        default:          draw_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/baccarat_ctrl.sv
// rtl/baccarat_ctrl.sv - baccarat hand sequencing controller
// Purpose: steps the deal, applies natural / player-draw / banker rules,
//          latches the win lights when the hand is scored.
// Ports: slow_clock_i (clock, rising edge), reset_i (sync, active-high),
//        bus (baccarat_ctrl_if.master: scores and pcard3 in; one-hot card loads,
//        win lights and done out).
module baccarat_ctrl
  import baccarat_pkg::*;
#(
  parameter logic [3:0] NATURAL_MIN = 4'd8,
  parameter logic [3:0] STAND_MIN   = 4'd6
) (
  input  logic             slow_clock_i,
  input  logic             reset_i,
  baccarat_ctrl_if.master  bus
);

  localparam logic [3:0] ST_DEAL_P1   = DEAL_P1;
  localparam logic [3:0] ST_DEAL_D1   = DEAL_D1;
  localparam logic [3:0] ST_DEAL_P2   = DEAL_P2;
  localparam logic [3:0] ST_DEAL_D2   = DEAL_D2;
  localparam logic [3:0] ST_EVAL      = EVAL;
  localparam logic [3:0] ST_DEAL_P3   = DEAL_P3;
  localparam logic [3:0] ST_BANK_EVAL = BANK_EVAL;
  localparam logic [3:0] ST_DEAL_D3   = DEAL_D3;
  localparam logic [3:0] ST_SCORE     = SCORE;
  localparam logic [3:0] ST_DONE      = DONE;

  // Banker draws on its two-card score up to this value when the player stood.
  localparam logic [3:0] BANK_NO_P3_MAX = 4'd5;

  logic [3:0] state_q, state_d;
  logic       player_q, player_d;
  logic       dealer_q, dealer_d;
  logic       bank_draw;

  banker_draw_rule u_banker_draw_rule (
    .dscore_i (bus.dscore),
    .pcard3_i (bus.pcard3),
    .draw_o   (bank_draw)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DEAL_P1: state_d = ST_DEAL_D1;
      ST_DEAL_D1: state_d = ST_DEAL_P2;
      ST_DEAL_P2: state_d = ST_DEAL_D2;
      ST_DEAL_D2: state_d = ST_EVAL;
      ST_EVAL: begin
        // Out-of-range scores (>9) land here as naturals by plain unsigned compare.
        if (bus.pscore >= NATURAL_MIN || bus.dscore >= NATURAL_MIN) begin
          state_d = ST_SCORE;
        end else if (bus.pscore < STAND_MIN) begin
          state_d = ST_DEAL_P3;
        end else if (bus.dscore <= BANK_NO_P3_MAX) begin
          state_d = ST_DEAL_D3;
        end else begin
          state_d = ST_SCORE;
        end
      end
      ST_DEAL_P3:   state_d = ST_BANK_EVAL;
      ST_BANK_EVAL: state_d = bank_draw ? ST_DEAL_D3 : ST_SCORE;
      ST_DEAL_D3:   state_d = ST_SCORE;
      ST_SCORE:     state_d = ST_DONE;
      ST_DONE:      state_d = ST_DONE;
      default:      state_d = ST_DEAL_P1;
    endcase
  end

  // A tie lights both, so each light is simply "my score is not lower".
  always_comb begin
    player_d = player_q;
    dealer_d = dealer_q;
    if (state_q == ST_SCORE) begin
      player_d = (bus.pscore >= bus.dscore);
      dealer_d = (bus.dscore >= bus.pscore);
    end
  end

  always_ff @(posedge slow_clock_i) begin
    if (reset_i) begin
      state_q  <= ST_DEAL_P1;
      player_q <= 1'b0;
      dealer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      dealer_q <= dealer_d;
    end
  end

  // Loads are gated by reset so an abandoned hand never captures a card.
  assign bus.load_pcard1 = !reset_i && (state_q == ST_DEAL_P1);
  assign bus.load_dcard1 = !reset_i && (state_q == ST_DEAL_D1);
  assign bus.load_pcard2 = !reset_i && (state_q == ST_DEAL_P2);
  assign bus.load_dcard2 = !reset_i && (state_q == ST_DEAL_D2);
  assign bus.load_pcard3 = !reset_i && (state_q == ST_DEAL_P3);
  assign bus.load_dcard3 = !reset_i && (state_q == ST_DEAL_D3);
  assign bus.done        = !reset_i && (state_q == ST_DONE);

  assign bus.player_win_light = player_q;
  assign bus.dealer_win_light = dealer_q;

endmodule

// File: tb/tb_baccarat_ctrl.sv
// tb/tb_baccarat_ctrl.sv - self-checking bench for baccarat_ctrl and banker_draw_rule
module tb_baccarat_ctrl;

  logic clk;
  logic rst;
  baccarat_ctrl_if bus ();

  baccarat_ctrl dut (
    .slow_clock_i (clk),
    .reset_i      (rst),
    .bus          (bus)
  );

  logic [3:0] t_d;
  logic [3:0] t_c;
  logic       t_draw;

  banker_draw_rule u_rule_tb (
    .dscore_i (t_d),
    .pcard3_i (t_c),
    .draw_o   (t_draw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected outputs for the current cycle, published by the stimulus process.
  logic       chk_en = 1'b0;
  int         exp_code = 0;   // 0 none, 1 P1, 2 D1, 3 P2, 4 D2, 5 P3, 6 D3
  logic       exp_done = 1'b0;
  logic       lights_chk = 1'b0;
  logic       exp_pl = 1'b0;
  logic       exp_dl = 1'b0;
  int         p3_cnt = 0;
  int         d3_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [5:0] act;
      logic [5:0] expv;
      act  = {bus.load_dcard3, bus.load_pcard3, bus.load_dcard2,
              bus.load_pcard2, bus.load_dcard1, bus.load_pcard1};
      expv = (exp_code == 0) ? 6'b0 : 6'(1 << (exp_code - 1));
      chk("loads", int'(act), int'(expv));
      chk("load_onehot", int'($countones(act) <= 1), 1);
      chk("done", int'(bus.done), int'(exp_done));
      if (lights_chk) begin
        chk("player_light", int'(bus.player_win_light), int'(exp_pl));
        chk("dealer_light", int'(bus.dealer_win_light), int'(exp_dl));
      end
      if (bus.load_pcard3) p3_cnt++;
      if (bus.load_dcard3) d3_cnt++;
    end
  end

  // Banker draw table: bit v of mask[dscore] set means draw on third-card value v.
  function automatic logic model_draw(input int d, input int rank);
    logic [9:0] mask [0:15];
    int v;
    for (int i = 0; i < 16; i++) mask[i] = 10'h000;
    mask[0] = 10'h3FF; mask[1] = 10'h3FF; mask[2] = 10'h3FF;
    mask[3] = 10'h2FF; mask[4] = 10'h0FC; mask[5] = 10'h0F0;
    mask[6] = 10'h0C0;
    v = (rank >= 10) ? 0 : rank;
    return mask[d][v];
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic prev_known = 1'b0;
  logic prev_pl = 1'b0;
  logic prev_dl = 1'b0;

  // One hand: card-order trace from the game rules, scores pe/de during the deal,
  // pf/df at the scoring cycle. abort_at >= 0 stops the hand before that cycle.
  task automatic run_hand(input int pe, input int de, input int pc3,
                          input int pf, input int df, input int abort_at,
                          input int lit_len);
    int q[$];
    int first_done;
    q = '{1, 2, 3, 4, 0};
    if (pe >= 8 || de >= 8) begin
      q.push_back(0);
    end else if (pe < 6) begin
      q.push_back(5);
      q.push_back(0);
      if (model_draw(de, pc3)) q.push_back(6);
      q.push_back(0);
    end else if (de <= 5) begin
      q.push_back(6);
      q.push_back(0);
    end else begin
      q.push_back(0);
    end
    chk("trace_len", q.size(), lit_len);

    p3_cnt = 0;
    d3_cnt = 0;
    bus.pscore = 4'(pe);
    bus.dscore = 4'(de);
    bus.pcard3 = 4'(pc3);
    rst = 1'b1;
    exp_code = 0;
    exp_done = 1'b0;
    lights_chk = prev_known;
    exp_pl = prev_pl;
    exp_dl = prev_dl;
    chk_en = 1'b1;
    cycle();

    rst = 1'b0;
    lights_chk = 1'b1;
    exp_pl = 1'b0;
    exp_dl = 1'b0;
    prev_known = 1'b1;
    prev_pl = 1'b0;
    prev_dl = 1'b0;
    first_done = -1;
    for (int k = 0; k < q.size(); k++) begin
      if (k == abort_at) return;
      bus.pscore = 4'((k == q.size() - 1) ? pf : pe);
      bus.dscore = 4'((k == q.size() - 1) ? df : de);
      exp_code = q[k];
      cycle();
    end

    // Scores change after scoring to show the lights stay latched.
    bus.pscore = 4'd0;
    bus.dscore = 4'd9;
    exp_code = 0;
    exp_done = 1'b1;
    exp_pl = (pf >= df);
    exp_dl = (df >= pf);
    prev_pl = exp_pl;
    prev_dl = exp_dl;
    for (int k = 0; k < 3; k++) begin
      if (first_done < 0 && bus.done) first_done = q.size() + k;
      cycle();
    end
    chk("done_latency", first_done, lit_len);
  endtask

  initial begin
    rst = 1'b1;
    bus.pscore = 4'd0;
    bus.dscore = 4'd0;
    bus.pcard3 = 4'd0;
    t_d = 4'd0;
    t_c = 4'd0;
    cycle();

    // Natural: player 9 vs banker 3.
    run_hand(9, 3, 0, 9, 3, -1, 6);
    chk("nat_p3_pulses", p3_cnt, 0);
    chk("nat_d3_pulses", d3_cnt, 0);
    chk("nat_player_light", int'(bus.player_win_light), 1);
    chk("nat_dealer_light", int'(bus.dealer_win_light), 0);

    // Player draws 6, banker on 5 draws.
    run_hand(4, 5, 6, 4, 5, -1, 9);
    chk("draw_p3_pulses", p3_cnt, 1);
    chk("draw_d3_pulses", d3_cnt, 1);

    // Banker on 3 stands against an 8, draws against a queen.
    run_hand(2, 3, 8, 2, 3, -1, 8);
    chk("b3v8_d3_pulses", d3_cnt, 0);
    run_hand(2, 3, 12, 8, 8, -1, 9);
    chk("b3vQ_d3_pulses", d3_cnt, 1);

    // Player stands on 7, banker draws on 5; final tie.
    run_hand(7, 5, 0, 7, 7, -1, 7);
    chk("stand_p3_pulses", p3_cnt, 0);
    chk("stand_d3_pulses", d3_cnt, 1);
    chk("tie_player_light", int'(bus.player_win_light), 1);
    chk("tie_dealer_light", int'(bus.dealer_win_light), 1);

    // Reset while in BANK_EVAL, then a clean hand.
    run_hand(4, 5, 6, 4, 5, 6, 9);
    run_hand(6, 6, 0, 6, 4, -1, 6);

    // Boundaries: out-of-range banker score is natural; banker 7 stands;
    // missing third card counts as zero.
    run_hand(5, 12, 0, 5, 12, -1, 6);
    chk("range_dealer_light", int'(bus.dealer_win_light), 1);
    run_hand(5, 7, 3, 5, 7, -1, 8);
    run_hand(3, 4, 0, 3, 4, -1, 8);

    chk_en = 1'b0;
    rst = 1'b1;
    cycle();

    // Banker rule unit sweep, including the missing-card case.
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 14; c++) begin
        t_d = 4'(d);
        t_c = 4'(c);
        #1;
        chk($sformatf("rule_d%0d_c%0d", d, c), int'(t_draw), int'(model_draw(d, c)));
      end
    end
    t_d = 4'd3; t_c = 4'd8; #1;
    chk("rule_lit_3_8", int'(t_draw), 0);
    t_d = 4'd6; t_c = 4'd7; #1;
    chk("rule_lit_6_7", int'(t_draw), 1);
    t_d = 4'd4; t_c = 4'd1; #1;
    chk("rule_lit_4_1", int'(t_draw), 0);
    t_d = 4'd5; t_c = 4'd4; #1;
    chk("rule_lit_5_4", int'(t_draw), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
